// File: rtl/csr_exec.sv
// csr_exec: execute-stage sequencer for Zicsr instructions.
// Accepts one decoded CSR op, reads the CSR, issues at most one write strobe
// with the read-modify-write value, then returns the old value to writeback.
module csr_exec #(
    parameter int unsigned MXLEN = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_funct3,
    input  logic [11:0]      op_csr_addr,
    input  logic [4:0]       op_rs1_idx,
    input  logic [MXLEN-1:0] op_rs1_data,
    input  logic [4:0]       op_zimm,
    input  logic [4:0]       op_rd_idx,
    output logic [11:0]      csr_addr,
    input  logic [MXLEN-1:0] csr_rdata,
    input  logic             csr_illegal,
    output logic [MXLEN-1:0] csr_wdata,
    output logic             csr_we,
    output logic             rd_we,
    output logic [4:0]       rd_idx,
    output logic [MXLEN-1:0] rd_data,
    output logic             exc_illegal,
    output logic             done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [2:0]       funct3_q;
    logic [11:0]      addr_q;
    logic [4:0]       rs1_idx_q;
    logic [MXLEN-1:0] rs1_data_q;
    logic [4:0]       zimm_q;
    logic [4:0]       rd_idx_q;
    logic [MXLEN-1:0] old_q;
    logic             illegal_q;

    logic             funct3_bad;
    logic             do_write;
    logic [MXLEN-1:0] src;
    logic [MXLEN-1:0] new_val;

    // Operand selection, write qualification and read-modify-write value.
    always_comb begin
        funct3_bad = (funct3_q[1:0] == 2'b00);
        src        = funct3_q[2] ? {{(MXLEN-5){1'b0}}, zimm_q} : rs1_data_q;
        if (funct3_q[1:0] == 2'b01) begin
            do_write = 1'b1;
        end else if (funct3_q[2]) begin
            do_write = (zimm_q != 5'd0);
        end else begin
            do_write = (rs1_idx_q != 5'd0);
        end
        case (funct3_q[1:0])
            2'b01:   new_val = src;
            2'b10:   new_val = old_q | src;
            2'b11:   new_val = old_q & ~src;
            default: new_val = '0;
        endcase
    end

    // Fixed four-state walk; illegal ops still traverse every state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (op_valid) state_d = READ;
            READ:    state_d = WRITE;
            WRITE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // State, op latch on accept and old-value/illegal capture in READ.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= IDLE;
            funct3_q   <= 3'd0;
            addr_q     <= 12'd0;
            rs1_idx_q  <= 5'd0;
            rs1_data_q <= '0;
            zimm_q     <= 5'd0;
            rd_idx_q   <= 5'd0;
            old_q      <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && op_valid) begin
                funct3_q   <= op_funct3;
                addr_q     <= op_csr_addr;
                rs1_idx_q  <= op_rs1_idx;
                rs1_data_q <= op_rs1_data;
                zimm_q     <= op_zimm;
                rd_idx_q   <= op_rd_idx;
            end
            if (state_q == READ) begin
                // Read data of a malformed funct3 is discarded.
                old_q     <= funct3_bad ? '0 : csr_rdata;
                illegal_q <= csr_illegal | funct3_bad
                             | (do_write && addr_q[11:10] == 2'b11);
            end
        end
    end

    // Strobes are masked by reset so an aborted op never writes or retires.
    always_comb begin
        op_ready    = (state_q == IDLE);
        csr_addr    = addr_q;
        csr_wdata   = new_val;
        csr_we      = (state_q == WRITE) && !reset && do_write && !illegal_q;
        done        = (state_q == RESP) && !reset;
        rd_we       = done && !illegal_q && (rd_idx_q != 5'd0);
        exc_illegal = done && illegal_q;
        rd_idx      = rd_idx_q;
        rd_data     = illegal_q ? '0 : old_q;
    end

endmodule

// File: tb/tb_csr_exec.sv
// Randomized self-checking bench for csr_exec against a rule-level reference model.
module tb_csr_exec;

    logic        CLK = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_funct3;
    logic [11:0] op_csr_addr;
    logic [4:0]  op_rs1_idx;
    logic [31:0] op_rs1_data;
    logic [4:0]  op_zimm;
    logic [4:0]  op_rd_idx;
    logic [11:0] csr_addr;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic [31:0] csr_wdata;
    logic        csr_we;
    logic        rd_we;
    logic [4:0]  rd_idx;
    logic [31:0] rd_data;
    logic        exc_illegal;
    logic        done;

    int n_total = 0;
    int n_bad   = 0;

    csr_exec #(.MXLEN(32)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_funct3   (op_funct3),
        .op_csr_addr (op_csr_addr),
        .op_rs1_idx  (op_rs1_idx),
        .op_rs1_data (op_rs1_data),
        .op_zimm     (op_zimm),
        .op_rd_idx   (op_rd_idx),
        .csr_addr    (csr_addr),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .csr_wdata   (csr_wdata),
        .csr_we      (csr_we),
        .rd_we       (rd_we),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .exc_illegal (exc_illegal),
        .done        (done)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    // Architectural rules of a Zicsr op: what the CSR file and writeback should see.
    task automatic model(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1i,
                         input logic [31:0] r1d, input logic [4:0] z, input logic [4:0] rd,
                         input logic [31:0] rdata, input logic cill,
                         output logic we, output logic [31:0] wd, output logic rwe,
                         output logic [31:0] rdd, output logic exc);
        logic [31:0] src;
        logic [31:0] old;
        logic        bad, dw, ill;
        bad = (f3 == 3'b000) || (f3 == 3'b100);
        src = f3[2] ? {27'd0, z} : r1d;
        old = bad ? 32'd0 : rdata;
        if (f3 == 3'b001 || f3 == 3'b101) dw = 1'b1;
        else if (f3 == 3'b110 || f3 == 3'b111) dw = (z != 0);
        else dw = (r1i != 0);
        ill = cill || bad || (dw && a >= 12'hC00);
        if (f3 == 3'b001 || f3 == 3'b101) wd = src;
        else if (f3 == 3'b010 || f3 == 3'b110) wd = old | src;
        else wd = old & ~src;
        we  = dw && !ill;
        rwe = !ill && (rd != 0);
        rdd = ill ? 32'd0 : old;
        exc = ill;
    endtask

    // Present an op at the current negedge; returns 1ns after the accepting edge.
    task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1i,
                         input logic [31:0] r1d, input logic [4:0] z, input logic [4:0] rd,
                         input logic [31:0] rdata, input logic cill);
        int k = 0;
        while (!op_ready && k < 8) begin
            @(negedge CLK);
            k++;
        end
        check("op_ready_before_accept", {31'd0, op_ready}, 32'd1);
        op_valid    = 1'b1;
        op_funct3   = f3;
        op_csr_addr = a;
        op_rs1_idx  = r1i;
        op_rs1_data = r1d;
        op_zimm     = z;
        op_rd_idx   = rd;
        csr_rdata   = rdata;
        csr_illegal = cill;
        @(posedge CLK);
        #1;
        // Decode keeps valid high with junk while busy; the block must ignore it.
        op_funct3   = 3'($urandom);
        op_csr_addr = 12'($urandom);
        op_rs1_idx  = 5'($urandom);
        op_rs1_data = $urandom;
        op_zimm     = 5'($urandom);
        op_rd_idx   = 5'($urandom);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1i,
                          input logic [31:0] r1d, input logic [4:0] z, input logic [4:0] rd,
                          input logic [31:0] rdata, input logic cill);
        logic        we, rwe, exc;
        logic [31:0] wd, rdd;
        model(f3, a, r1i, r1d, z, rd, rdata, cill, we, wd, rwe, rdd, exc);
        issue(f3, a, r1i, r1d, z, rd, rdata, cill);
        @(negedge CLK);
        check("read_ready", {31'd0, op_ready}, 32'd0);
        check("read_addr", {20'd0, csr_addr}, {20'd0, a});
        check("read_we", {31'd0, csr_we}, 32'd0);
        check("read_done", {31'd0, done}, 32'd0);
        @(negedge CLK);
        check("write_we", {31'd0, csr_we}, {31'd0, we});
        if (we) check("write_wdata", csr_wdata, wd);
        check("write_addr", {20'd0, csr_addr}, {20'd0, a});
        check("write_done", {31'd0, done}, 32'd0);
        csr_rdata   = $urandom;
        csr_illegal = 1'($urandom);
        @(negedge CLK);
        check("resp_done", {31'd0, done}, 32'd1);
        check("resp_csr_we", {31'd0, csr_we}, 32'd0);
        check("resp_rd_we", {31'd0, rd_we}, {31'd0, rwe});
        check("resp_exc", {31'd0, exc_illegal}, {31'd0, exc});
        check("resp_rd_data", rd_data, rdd);
        if (rwe) check("resp_rd_idx", {27'd0, rd_idx}, {27'd0, rd});
        op_valid = 1'b0;
        @(negedge CLK);
        check("idle_ready", {31'd0, op_ready}, 32'd1);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_rd_we", {31'd0, rd_we}, 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        op_valid    = 1'b0;
        op_funct3   = 3'd0;
        op_csr_addr = 12'd0;
        op_rs1_idx  = 5'd0;
        op_rs1_data = 32'd0;
        op_zimm     = 5'd0;
        op_rd_idx   = 5'd0;
        csr_rdata   = 32'd0;
        csr_illegal = 1'b0;
        repeat (3) @(posedge CLK);
        #1 reset = 1'b0;
        @(negedge CLK);
        check("rst_ready", {31'd0, op_ready}, 32'd1);
        check("rst_csr_we", {31'd0, csr_we}, 32'd0);
        check("rst_rd_we", {31'd0, rd_we}, 32'd0);
        check("rst_exc", {31'd0, exc_illegal}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_csr_addr", {20'd0, csr_addr}, 32'd0);
        check("rst_csr_wdata", csr_wdata, 32'd0);
        check("rst_rd_idx", {27'd0, rd_idx}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);

        // Directed cases.
        run_op(3'b001, 12'h340, 5'd1, 32'hDEADBEEF, 5'd0, 5'd5, 32'h12, 1'b0);
        run_op(3'b010, 12'h300, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd3, 32'h88, 1'b0);
        run_op(3'b011, 12'h300, 5'd2, 32'h8, 5'd0, 5'd3, 32'h88, 1'b0);
        run_op(3'b110, 12'h300, 5'd7, 32'h5, 5'd0, 5'd4, 32'h77, 1'b0);
        run_op(3'b111, 12'h300, 5'd7, 32'h5, 5'd0, 5'd4, 32'h77, 1'b0);
        run_op(3'b101, 12'h305, 5'd0, 32'h0, 5'h1F, 5'd6, 32'hABCD, 1'b0);
        run_op(3'b001, 12'hF14, 5'd1, 32'h1, 5'd0, 5'd8, 32'h55, 1'b0);
        run_op(3'b010, 12'hF14, 5'd0, 32'h1, 5'd0, 5'd8, 32'h55, 1'b0);
        run_op(3'b001, 12'h7FF, 5'd1, 32'h1, 5'd0, 5'd8, 32'h55, 1'b1);
        run_op(3'b100, 12'h340, 5'd1, 32'h1, 5'd3, 5'd8, 32'h55, 1'b0);
        run_op(3'b001, 12'h340, 5'd1, 32'h1234, 5'd0, 5'd0, 32'h99, 1'b0);

        // Reset during the WRITE cycle aborts the op.
        issue(3'b001, 12'h340, 5'd1, 32'hCAFE, 5'd0, 5'd9, 32'h11, 1'b0);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        reset    = 1'b1;
        op_valid = 1'b0;
        @(negedge CLK);
        check("abort_csr_we", {31'd0, csr_we}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(posedge CLK);
        #1 reset = 1'b0;
        @(negedge CLK);
        check("abort_ready", {31'd0, op_ready}, 32'd1);
        check("abort_done_after", {31'd0, done}, 32'd0);
        check("abort_rd_we", {31'd0, rd_we}, 32'd0);
        @(negedge CLK);
        check("abort_still_idle", {31'd0, done}, 32'd0);

        // Randomized ops, issued back to back.
        for (int i = 0; i < 300; i++) begin
            logic [4:0]  r1i, z;
            logic [11:0] a;
            r1i = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            z   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            a   = 12'($urandom);
            run_op(3'($urandom), a, r1i, $urandom, z, 5'($urandom), $urandom,
                   ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
